// File: rtl/cpu_pkg.sv
// Shared CPU definitions: status flag bit positions and the reset image of P.
package cpu_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_I = 2;
    localparam int FLAG_D = 3;
    localparam int FLAG_B = 4;
    localparam int FLAG_U = 5;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;

    localparam logic [7:0] P_RESET_DEFAULT = 8'h24;

endpackage

// File: rtl/cpu_status_reg.sv
// 6502/2A03 status register P with stack-push image and poll-sampled IRQ inhibit.
// Define DECIMAL_FLAG_EN to make D a real register; otherwise D reads 0.
module cpu_status_reg
    import cpu_pkg::*;
#(
    parameter logic [7:0] P_RESET = P_RESET_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] res_in,
    input  logic       cout_in,
    input  logic       ovf_in,
    input  logic [7:0] data_in,
    input  logic       upd_nz,
    input  logic       upd_c,
    input  logic       upd_v,
    input  logic       bit_en,
    input  logic       set_c,
    input  logic       clr_c,
    input  logic       set_i,
    input  logic       clr_i,
    input  logic       set_d,
    input  logic       clr_d,
    input  logic       clr_v,
    input  logic       pull_en,
    input  logic       push_b,
    input  logic       poll_strobe,
    output logic [7:0] p_out,
    output logic [7:0] p_push,
    output logic       c_out,
    output logic       z_out,
    output logic       n_out,
    output logic       v_out,
    output logic       irq_inhibit
);

    logic n, v, d, i, z, c;
    logic res_zero;

    assign res_zero = (res_in == 8'h00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n           <= P_RESET[FLAG_N];
            v           <= P_RESET[FLAG_V];
            i           <= P_RESET[FLAG_I];
            z           <= P_RESET[FLAG_Z];
            c           <= P_RESET[FLAG_C];
            irq_inhibit <= 1'b1;
        end else begin
            if (pull_en)     n <= data_in[FLAG_N];
            else if (bit_en) n <= data_in[7];
            else if (upd_nz) n <= res_in[7];

            if (pull_en)     v <= data_in[FLAG_V];
            else if (bit_en) v <= data_in[6];
            else if (clr_v)  v <= 1'b0;
            else if (upd_v)  v <= ovf_in;

            if (pull_en)     z <= data_in[FLAG_Z];
            else if (bit_en) z <= res_zero;
            else if (upd_nz) z <= res_zero;

            if (pull_en)     c <= data_in[FLAG_C];
            else if (set_c)  c <= 1'b1;
            else if (clr_c)  c <= 1'b0;
            else if (upd_c)  c <= cout_in;

            if (pull_en)     i <= data_in[FLAG_I];
            else if (set_i)  i <= 1'b1;
            else if (clr_i)  i <= 1'b0;

            // Sample the pre-edge I so CLI/SEI/PLP take effect one poll late.
            if (poll_strobe) irq_inhibit <= i;
        end
    end

`ifdef DECIMAL_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          d <= P_RESET[FLAG_D];
        else if (pull_en) d <= data_in[FLAG_D];
        else if (set_d)   d <= 1'b1;
        else if (clr_d)   d <= 1'b0;
    end
    logic unused_bits;
    assign unused_bits = ^data_in[5:4];
`else
    assign d = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{set_d, clr_d, data_in[5:3]};
`endif

    assign p_out  = {n, v, 1'b1, 1'b1, d, i, z, c};
    assign p_push = {n, v, 1'b1, push_b, d, i, z, c};
    assign c_out  = c;
    assign z_out  = z;
    assign n_out  = n;
    assign v_out  = v;

endmodule

// File: tb/tb_cpu_status_reg.sv
// Directed vector bench for cpu_status_reg.
module tb_cpu_status_reg;

    localparam logic [13:0] K_NZ   = 14'h0001;
    localparam logic [13:0] K_C    = 14'h0002;
    localparam logic [13:0] K_V    = 14'h0004;
    localparam logic [13:0] K_BIT  = 14'h0008;
    localparam logic [13:0] K_SC   = 14'h0010;
    localparam logic [13:0] K_CC   = 14'h0020;
    localparam logic [13:0] K_SI   = 14'h0040;
    localparam logic [13:0] K_CI   = 14'h0080;
    localparam logic [13:0] K_SD   = 14'h0100;
    localparam logic [13:0] K_CD   = 14'h0200;
    localparam logic [13:0] K_CV   = 14'h0400;
    localparam logic [13:0] K_PULL = 14'h0800;
    localparam logic [13:0] K_PB   = 14'h1000;
    localparam logic [13:0] K_POLL = 14'h2000;

`ifdef DECIMAL_FLAG_EN
    localparam logic [7:0] D_MASK = 8'hFF;
`else
    localparam logic [7:0] D_MASK = 8'hF7;
`endif

    typedef struct {
        logic [7:0]  res;
        logic        cout;
        logic        ovf;
        logic [7:0]  data;
        logic [13:0] ctl;
        logic [7:0]  exp_p;
        logic        exp_inh;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] res_in, data_in;
    logic       cout_in, ovf_in;
    logic       upd_nz, upd_c, upd_v, bit_en;
    logic       set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v;
    logic       pull_en, push_b, poll_strobe;
    logic [7:0] p_out, p_push;
    logic       c_out, z_out, n_out, v_out, irq_inhibit;

    int tests = 0;
    int fails = 0;
    vec_t vecs[15];

    always #5 clk = ~clk;

    cpu_status_reg dut (
        .clk(clk), .rst(rst),
        .res_in(res_in), .cout_in(cout_in), .ovf_in(ovf_in),
        .data_in(data_in),
        .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v), .bit_en(bit_en),
        .set_c(set_c), .clr_c(clr_c), .set_i(set_i), .clr_i(clr_i),
        .set_d(set_d), .clr_d(clr_d), .clr_v(clr_v),
        .pull_en(pull_en), .push_b(push_b), .poll_strobe(poll_strobe),
        .p_out(p_out), .p_push(p_push),
        .c_out(c_out), .z_out(z_out), .n_out(n_out), .v_out(v_out),
        .irq_inhibit(irq_inhibit)
    );

    always @(posedge clk) begin
        if (!rst) assert (!(pull_en && set_i))
            else $error("pull_en and set_i asserted together");
    end

    task automatic check8(input string name, input logic [7:0] act,
                          input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        res_in      = t.res;
        cout_in     = t.cout;
        ovf_in      = t.ovf;
        data_in     = t.data;
        upd_nz      = |(t.ctl & K_NZ);
        upd_c       = |(t.ctl & K_C);
        upd_v       = |(t.ctl & K_V);
        bit_en      = |(t.ctl & K_BIT);
        set_c       = |(t.ctl & K_SC);
        clr_c       = |(t.ctl & K_CC);
        set_i       = |(t.ctl & K_SI);
        clr_i       = |(t.ctl & K_CI);
        set_d       = |(t.ctl & K_SD);
        clr_d       = |(t.ctl & K_CD);
        clr_v       = |(t.ctl & K_CV);
        pull_en     = |(t.ctl & K_PULL);
        push_b      = |(t.ctl & K_PB);
        poll_strobe = |(t.ctl & K_POLL);
    endtask

    task automatic idle();
        vec_t t;
        t = '{8'h00, 1'b0, 1'b0, 8'h00, 14'h0000, 8'h00, 1'b0};
        drive(t);
    endtask

    initial begin
        logic [7:0] ep, epush;
        vecs[0]  = '{8'h00, 1'b1, 1'b1, 8'h00, K_NZ | K_C | K_V,  8'h77, 1'b1};
        vecs[1]  = '{8'h00, 1'b0, 1'b0, 8'hC0, K_BIT | K_V,       8'hF7, 1'b1};
        vecs[2]  = '{8'h80, 1'b0, 1'b0, 8'h00, K_NZ | K_C,        8'hF4, 1'b1};
        vecs[3]  = '{8'h00, 1'b0, 1'b1, 8'h00, K_CV | K_V | K_PB, 8'hB4, 1'b1};
        vecs[4]  = '{8'h00, 1'b0, 1'b0, 8'h00, K_SC | K_CC,       8'hB5, 1'b1};
        vecs[5]  = '{8'h00, 1'b1, 1'b0, 8'h00, K_CC | K_C,        8'hB4, 1'b1};
        vecs[6]  = '{8'h00, 1'b0, 1'b0, 8'hFF, K_PULL | K_CC,     8'hFF, 1'b1};
        vecs[7]  = '{8'h00, 1'b0, 1'b0, 8'h00, K_PULL | K_PB,     8'h30, 1'b1};
        vecs[8]  = '{8'h00, 1'b0, 1'b0, 8'h00, K_SI | K_POLL,     8'h34, 1'b0};
        vecs[9]  = '{8'h00, 1'b0, 1'b0, 8'h00, K_CI | K_POLL,     8'h30, 1'b1};
        vecs[10] = '{8'h00, 1'b0, 1'b0, 8'h00, K_POLL,            8'h30, 1'b0};
        vecs[11] = '{8'h00, 1'b0, 1'b0, 8'h00, K_SD,              8'h38, 1'b0};
        vecs[12] = '{8'h00, 1'b0, 1'b0, 8'h00, K_CD,              8'h30, 1'b0};
        vecs[13] = '{8'h00, 1'b0, 1'b0, 8'h00, K_NZ,              8'h32, 1'b0};
        vecs[14] = '{8'h01, 1'b0, 1'b0, 8'h00, K_NZ | K_PB,       8'h30, 1'b0};

        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check8("reset_p", p_out, 8'h34);
        check8("reset_inh", {7'd0, irq_inhibit}, 8'h01);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            drive(vecs[k]);
            @(posedge clk);
            #1;
            ep    = vecs[k].exp_p & D_MASK;
            epush = (ep & 8'hEF) | ((vecs[k].ctl & K_PB) != 0 ? 8'h10 : 8'h00);
            check8($sformatf("v%0d_p", k), p_out, ep);
            check8($sformatf("v%0d_push", k), p_push, epush);
            check8($sformatf("v%0d_inh", k), {7'd0, irq_inhibit},
                   {7'd0, vecs[k].exp_inh});
            check8($sformatf("v%0d_flags", k), {4'd0, n_out, v_out, z_out, c_out},
                   {4'd0, ep[7], ep[6], ep[1], ep[0]});
        end

        // Asynchronous reset mid-cycle, no clock edge in between.
        @(negedge clk);
        idle();
        #2;
        rst = 1'b1;
        #1;
        check8("async_rst_p", p_out, 8'h34);
        check8("async_rst_inh", {7'd0, irq_inhibit}, 8'h01);

        // Updates during reset are discarded.
        set_c = 1'b1;
        clr_i = 1'b1;
        @(posedge clk);
        #1;
        check8("rst_hold_p", p_out, 8'h34);
        @(negedge clk);
        idle();
        rst = 1'b0;

        // Push image depends combinationally on push_b.
        push_b = 1'b1;
        #1;
        check8("push_b1", p_push, 8'h34);
        push_b = 1'b0;
        #1;
        check8("push_b0", p_push, 8'h24);

        // CLI latency: poll in same edge sees old I, next poll sees new I.
        @(negedge clk);
        clr_i = 1'b1;
        poll_strobe = 1'b1;
        @(posedge clk);
        #1;
        check8("cli_same_poll", {7'd0, irq_inhibit}, 8'h01);
        @(negedge clk);
        idle();
        @(posedge clk);
        #1;
        check8("cli_no_poll", {7'd0, irq_inhibit}, 8'h01);
        @(negedge clk);
        poll_strobe = 1'b1;
        @(posedge clk);
        #1;
        check8("cli_next_poll", {7'd0, irq_inhibit}, 8'h00);
        check8("cli_p", p_out, 8'h30);
        @(negedge clk);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_status_reg.md
Name: cpu_status_reg

Overview:
- Holds the 6502/2A03 processor status register P (N V - B D I Z C) for the NES CPU core.
- Sits directly downstream of the ALU and consumes its RES, Cout and OVFout outputs.
- Presents C back to the ALU as its carry-in and supplies flags to the branch/control logic.
- Also provides the stack-push image of P and a poll-point-sampled interrupt inhibit, which gives the 6502 one-instruction CLI/SEI/PLP latency.

Parameters:
- P_RESET, 8'h24, P image loaded on reset. Bit5 is always 1; bit4 is not stored. Default gives I=1 and all other flags 0.

Ports:
- clk  in  1  system clock; all state on the rising edge
- rst  in  1  asynchronous, active-high reset
- res_in  in  8  ALU RES result
- cout_in  in  1  ALU Cout
- ovf_in  in  1  ALU OVFout
- data_in  in  8  data bus byte (stack pull value or BIT operand)
- upd_nz  in  1  load N<=res_in[7], Z<=(res_in==0)
- upd_c  in  1  load C<=cout_in
- upd_v  in  1  load V<=ovf_in
- bit_en  in  1  BIT: N<=data_in[7], V<=data_in[6], Z<=(res_in==0); res_in is the ALU AND result
- set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v  in  1 each  explicit flag ops (SEC/CLC/SEI/CLI/SED/CLD/CLV; set_i also used by interrupt entry)
- pull_en  in  1  PLP/RTI: load N,V,D,I,Z,C from data_in; data_in[5:4] ignored
- push_b  in  1  B value inserted into p_push (1 = BRK/PHP, 0 = IRQ/NMI)
- poll_strobe  in  1  interrupt poll point from control unit
- p_out  out  8  live P: {N,V,1,1,D,I,Z,C}
- p_push  out  8  {N,V,1,push_b,D,I,Z,C} for stack write (combinational)
- c_out, z_out, n_out, v_out  out  1 each  individual flags (c_out feeds ALU Cin)
- irq_inhibit  out  1  I value sampled at the last poll_strobe

Behaviour:
- Reset (asynchronous, any time, including mid-instruction):
  - Flags take P_RESET values; irq_inhibit<=1.
  - All updates in the same edge are discarded.
- Flags are single registers that update on the rising edge only. Outputs are direct register views with no combinational path from inputs, except p_push's dependence on push_b.
- Per-edge priority, per flag:
  - pull_en overrides everything.
  - Then bit_en for N/V/Z.
  - Then explicit set/clr (set wins if set and clr are both asserted).
  - Then upd_* from the ALU.
  - Flags with no asserted source hold their value.
- Independent controls are legal together, e.g. upd_nz+upd_c+upd_v for ADC/SBC/CMP, or upd_nz+upd_c for shifts.
- Z compare is on all 8 bits of res_in.
- Latency: one cycle; a flag updated at edge k is visible on outputs after edge k.
- irq_inhibit: on an edge with poll_strobe=1, irq_inhibit<=I as registered before that edge. An I change in the same edge is therefore not seen until the next poll.
- B (bit4) is never stored. p_out bit4 reads 1; pulled data_in[4] is discarded.
- No internal state machine beyond the irq_inhibit sampler.
- pull_en with set_i in the same edge: pull wins. The control unit must not assert both; the bench checks this with an assertion.

Optional Feature:
- DECIMAL_FLAG_EN defined: D is a real register driven by set_d/clr_d/pull_en/P_RESET[3]; p_out/p_push bit3 = D.
- Not defined: D is hardwired to 0, set_d/clr_d/data_in[3] are ignored, and bit3 reads 0.
- In both builds the 2A03 ALU performs no decimal arithmetic; D is storage only.

Decomposition:
- Shared cpu_pkg holds:
  - flag bit index constants FLAG_C=0, FLAG_Z=1, FLAG_I=2, FLAG_D=3, FLAG_B=4, FLAG_U=5, FLAG_V=6, FLAG_N=7
  - the P_RESET default value
- No sub-module; a single flat module. The irq_inhibit sampler is inline.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> p_out=8'h34, irq_inhibit=1 immediately, without waiting for a clock edge.
- ADC flags: res_in=8'h00, cout_in=1, ovf_in=1, upd_nz/upd_c/upd_v=1 -> next cycle p_out=8'hF7 & ~8'h80 → 8'h77 (N=0, V=1, Z=1, C=1, I=1).
- BIT: data_in=8'hC0, res_in=8'h00, bit_en=1 with upd_v=1, ovf_in=0 -> N=1, V=1, Z=1 (bit_en wins over upd_v).
- PLP: data_in=8'hFF, pull_en=1, clr_c=1 -> p_out=8'hFF with DECIMAL_FLAG_EN, 8'hF7 without; C=1 (pull wins).
- CLI latency: I=1, clr_i with poll_strobe in the same edge -> irq_inhibit stays 1. The next poll_strobe -> irq_inhibit=0.
- Push image: P=8'h24, push_b=1 -> p_push=8'h34; push_b=0 -> p_push=8'h24. set_c and clr_c together -> C=1.
